// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared constants and arbiter state type for the UART transmit path
//
// Purpose : common definitions imported by uart_tx_arbiter and rr_pick.
// Contents: BYTE_W, CLK_HZ, arb_state_e, wrap_inc().
package uart_ctrl_pkg;

    localparam int BYTE_W = 8;
    localparam int CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } arb_state_e;

    // Increment an index modulo n (n need not be a power of two).
    function automatic int wrap_inc(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority picker
//
// Purpose : selects the first set request searching upward from ptr,
//           wrapping modulo N_REQ.
// Ports   : req        in  N_REQ  request vector
//           ptr        in  ID_W   highest-priority index
//           gnt_onehot out N_REQ  one-hot winner (all zero when no request)
//           gnt_id     out ID_W   winner index (0 when no request)
module rr_pick
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]  gnt_id
);

    // Scan from the lowest priority offset to the highest so the last hit,
    // which is the one closest to ptr, overwrites any earlier hit.
    always_comb begin
        int idx;
        idx        = 0;
        gnt_onehot = '0;
        gnt_id     = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (req[idx]) begin
                gnt_onehot      = '0;
                gnt_onehot[idx] = 1'b1;
                gnt_id          = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter with packet lock for a shared UART transmitter
//
// Purpose : shares one uart_top transmitter between N_REQ byte streams. A
//           granted requester keeps the transmitter until it sends a byte
//           flagged last, or until it leaves req_valid low for LOCK_TIMEOUT
//           cycles between bytes.
// Ports   : clk, rst            clock, asynchronous active-high reset
//           req_valid/data/last requester byte streams (byte i at [8i+7:8i])
//           req_ready           one-hot accept
//           uart_tx_start/data  start pulse and held byte to uart_top
//           uart_tx_done        end-of-frame pulse from uart_top
//           grant_id            current or last owner
//           busy                high whenever not IDLE
//           lock_timeout        one-cycle pulse on forced lock release
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int TO_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [BYTE_W*N_REQ-1:0]  req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     uart_tx_start,
    output logic [BYTE_W-1:0]        uart_tx_data,
    input  logic                     uart_tx_done,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     lock_timeout
);

    localparam int              ID_W    = $clog2(N_REQ);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              lock_to_q, lock_to_d;

    logic [N_REQ-1:0]  pick_onehot;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   grant_inc;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req        (req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_id     (pick_id)
    );

    // Priority after the current owner releases: the requester just above it.
    assign grant_inc = ID_W'(wrap_inc(int'(grant_q), N_REQ));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            last_q    <= 1'b0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            to_cnt_q  <= '0;
            lock_to_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            to_cnt_q  <= to_cnt_d;
            lock_to_q <= lock_to_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        last_d    = last_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        to_cnt_d  = to_cnt_q;
        lock_to_d = 1'b0;
        req_ready = '0;

        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = pick_onehot;
                    data_d    = req_data[int'(pick_id)*BYTE_W +: BYTE_W];
                    last_d    = req_last[pick_id];
                    grant_d   = pick_id;
                    state_d   = START;
                end
            end

            // uart_tx_start is decoded from this state; a done seen here
            // belongs to no frame of ours and is ignored.
            START: begin
                state_d = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (uart_tx_done) begin
                    if (last_q) begin
                        rr_ptr_d = grant_inc;
                        state_d  = IDLE;
                    end else begin
                        to_cnt_d = '0;
                        state_d  = HOLD;
                    end
                end
            end

            // Locked to the owner; everyone else is ignored. A transfer in
            // the same cycle the counter hits its limit takes precedence.
            HOLD: begin
                req_ready[grant_q] = req_valid[grant_q];
                if (req_valid[grant_q]) begin
                    data_d  = req_data[int'(grant_q)*BYTE_W +: BYTE_W];
                    last_d  = req_last[grant_q];
                    state_d = START;
                end else if (to_cnt_q == TO_LAST) begin
                    lock_to_d = 1'b1;
                    rr_ptr_d  = grant_inc;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign uart_tx_start = (state_q == START);
    assign uart_tx_data  = data_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);
    assign lock_timeout  = lock_to_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter in uart_top between N_REQ byte-stream requesters, for example a command responder, a status reporter and a debug logger.
- Uses round-robin arbitration with optional packet lock: a requester keeps the transmitter until it presents a byte flagged last, or until it stalls past a timeout.
- Drives uart_top tx_start/tx_data and consumes tx_done.
- Sits between the requester logic and uart_top, in the same clk domain (50 MHz).

Parameters:
- N_REQ, 3, number of requesters (2..8).
- LOCK_TIMEOUT, 50000, cycles a locked requester may leave req_valid low before the lock is forcibly released (1 ms at 50 MHz).
- TO_W, 16, width of the timeout counter; must satisfy 2**TO_W > LOCK_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a byte on its slice of req_data.
- req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  N_REQ  byte of requester i is the final byte of its packet.
- req_ready  out  N_REQ  one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- uart_tx_start  out  1  one-cycle start pulse to uart_top.
- uart_tx_data  out  8  byte to uart_top; held stable from the start pulse until tx_done.
- uart_tx_done  in  1  one-cycle pulse from uart_top at end of the stop bit.
- grant_id  out  $clog2(N_REQ)  current or last owner.
- busy  out  1  high in every state except IDLE.
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly released.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, req_ready=0, uart_tx_start=0, uart_tx_data=8'h00, grant_id=0, busy=0, lock_timeout=0, rr_ptr=0, timeout counter=0, latched last flag=0.
- Reset asserted mid-frame aborts the transfer with no completion pulse. uart_top shares rst, so the line recovers together with this block.
- States: IDLE, START, WAIT_DONE, HOLD.
- IDLE:
  - The winner is the first requester with req_valid set, searching upward from rr_ptr and wrapping modulo N_REQ.
  - req_ready[winner] is driven combinationally high in the same cycle.
  - On that cycle, register req_data slice into uart_tx_data, req_last into the last flag, and winner into grant_id; go to START.
  - No valid requester: stay in IDLE with req_ready all zero.
- START: uart_tx_start=1 for exactly this cycle. An uart_tx_done arriving in this cycle is ignored. Go to WAIT_DONE.
- WAIT_DONE:
  - Waits for uart_tx_done with uart_tx_data unchanged; req_ready stays 0.
  - On done with last flag=1: rr_ptr=(grant_id+1) mod N_REQ, go to IDLE.
  - On done with last flag=0: clear the timeout counter, go to HOLD.
- HOLD:
  - Only requester grant_id may transfer; req_ready[grant_id]=req_valid[grant_id] combinationally.
  - On transfer: latch data and last flag as in IDLE, go to START.
  - Otherwise the counter increments each cycle. When it reaches LOCK_TIMEOUT-1 with no transfer: pulse lock_timeout, rr_ptr=grant_id+1 mod N_REQ, go to IDLE.
  - Other requesters' valid signals are ignored while in HOLD.
- Latency:
  - Accept cycle T, start pulse at T+1.
  - After tx_done at cycle D, the next accept can occur at D+1 (from IDLE or HOLD), so the next start pulse is at D+2.
- Simultaneous events:
  - A transfer in the same cycle the counter hits the limit wins: no timeout is signalled.
  - A requester may drop req_valid without penalty when not accepted.
- A single-byte packet is a byte with req_last=1; the grant then rotates after that one byte.
- Fairness: each requester waits at most N_REQ-1 packets, each bounded by the timeout between bytes.

Decomposition:
- Package uart_ctrl_pkg holds:
  - the state enum/localparams (IDLE=2'd0, START=2'd1, WAIT_DONE=2'd2, HOLD=2'd3);
  - BYTE_W=8;
  - the CLK_HZ=50_000_000 constant shared with uart_top.
- Sub-module rr_pick: combinational rotate-priority encoder with inputs req[N_REQ] and ptr, outputs gnt_onehot and gnt_id.
- The FSM, data latch and timeout counter live in uart_tx_arbiter.

Test Plan:
- Single requester 0 sends 8'h55 with last=1 → one uart_tx_start pulse with tx_data=8'h55; rx_data=8'h55 at rx_done; rr_ptr=1; busy returns to 0 the cycle after tx_done.
- Requesters 0, 1 and 2 each hold one single-byte packet (8'hA1, 8'hB2, 8'hC3) from reset → serial order A1, B2, C3. With 0 re-requesting 8'hA4 immediately, the following round gives A4 only after C3.
- Requester 1 sends packet 8'h10, 8'h11, 8'h12 (last on 8'h12) while requester 0 is valid throughout → wire order 10, 11, 12, then 0's byte; req_ready[0] stays 0 during the packet.
- Requester 2 sends 8'h20 with last=0, then drops req_valid; LOCK_TIMEOUT set to 100 → lock_timeout pulses exactly 100 cycles after entering HOLD; requester 0's pending byte starts on the next cycle after the return to IDLE.
- Assert rst during WAIT_DONE of byte 8'hFF → all outputs take their reset values immediately; a later byte 8'h3C is transmitted and received correctly.
- Hold uart_tx_done high during START (forced stub) → the FSM stays in WAIT_DONE until a later done pulse; no premature grant change.
